// File: rtl/race_pkg.sv
// Shared race definitions: state encoding and datapath widths.
// Also imported by the physics engine, so codes must stay fixed.
package race_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LAP_W   = 4;
  localparam int unsigned TIME_W  = 16;
  localparam int unsigned CD_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_SETTING   = 3'd1,
    ST_COUNTDOWN = 3'd3,
    ST_RACING    = 3'd4,
    ST_PAUSE     = 3'd5,
    ST_FINISH    = 3'd6
  } race_state_e;

endpackage

// File: rtl/race_sequencer_tick_gen.sv
// Physics-tick prescaler: counts 0..TICK_DIV-1 while run is high,
// holds its value while run is low, and returns to 0 on clear.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Prescaler counter; clear wins over run, neither means freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/race_sequencer.sv
// Race sequencer: IDLE -> SETTING -> COUNTDOWN -> RACING -> FINISH,
// with lap counting, 10 ms race timer and physics-tick generation.
// Optional feature macro PAUSE_EN: enables the PAUSE state driven by
// pause_btn; without it pause_btn is ignored and code 5 recovers to IDLE.
module race_sequencer
  import race_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 1_000_000,
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned COUNT_SECS    = 3,
  parameter int unsigned NUM_LAPS      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_btn,
  input  logic              pause_btn,
  input  logic              abort,
  input  logic              lap_pulse,
  output logic [2:0]        state,
  output logic [2:0]        countdown,
  output logic [3:0]        lap_count,
  output logic [15:0]       race_time,
  output logic              go_pulse,
  output logic              phys_tick
);

  localparam int unsigned SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SW-1:0]     SEC_LAST  = SW'(TICKS_PER_SEC - 1);
  localparam logic [CD_W-1:0]   CD_START  = CD_W'(COUNT_SECS);
  localparam logic [LAP_W-1:0]  LAP_FINAL = LAP_W'(NUM_LAPS);

  race_state_e       state_q, state_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic [LAP_W-1:0]  lap_q, lap_d, lap_inc;
  logic [TIME_W-1:0] time_q, time_d;
  logic [SW-1:0]     sec_q, sec_d;
  logic              go_q, go_d;
  logic              tick, run, hold, clear;

`ifndef PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause_btn;
`endif

  // Prescaler run/freeze/clear decode from the current state.
  always_comb begin
    run  = (state_q == ST_COUNTDOWN) || (state_q == ST_RACING);
`ifdef PAUSE_EN
    hold = (state_q == ST_PAUSE);
`else
    hold = 1'b0;
`endif
    clear = abort || !(run || hold);
  end

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (clear),
    .tick  (tick)
  );

  assign lap_inc = lap_q + 1'b1;

  // Next-state and counter updates; abort overrides every state.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    lap_d   = lap_q;
    time_d  = time_q;
    sec_d   = sec_q;
    go_d    = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cd_d    = '0;
      lap_d   = '0;
      time_d  = '0;
      sec_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cd_d   = '0;
          lap_d  = '0;
          time_d = '0;
          sec_d  = '0;
          if (start_btn) state_d = ST_SETTING;
        end
        ST_SETTING: begin
          if (start_btn) begin
            state_d = ST_COUNTDOWN;
            cd_d    = CD_START;
            sec_d   = '0;
          end
        end
        ST_COUNTDOWN: begin
          if (tick) begin
            if (sec_q == SEC_LAST) begin
              sec_d = '0;
              if (cd_q <= 3'd1) begin
                state_d = ST_RACING;
                cd_d    = '0;
                lap_d   = '0;
                time_d  = '0;
                go_d    = 1'b1;
              end else begin
                cd_d = cd_q - 1'b1;
              end
            end else begin
              sec_d = sec_q + 1'b1;
            end
          end
        end
        ST_RACING: begin
          if (tick && (time_q != '1)) time_d = time_q + 1'b1;
          // A lap on the same edge as pause is still counted; the
          // final lap beats pause so the race can never pause after it ends.
          if (lap_pulse) begin
            lap_d = lap_inc;
            if (lap_inc == LAP_FINAL) state_d = ST_FINISH;
`ifdef PAUSE_EN
            else if (pause_btn) state_d = ST_PAUSE;
`endif
          end
`ifdef PAUSE_EN
          else if (pause_btn) state_d = ST_PAUSE;
`endif
        end
`ifdef PAUSE_EN
        ST_PAUSE: begin
          if (pause_btn) state_d = ST_RACING;
        end
`endif
        ST_FINISH: begin
          if (start_btn) begin
            state_d = ST_IDLE;
            lap_d   = '0;
            time_d  = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cd_d    = '0;
          lap_d   = '0;
          time_d  = '0;
          sec_d   = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
      lap_q   <= '0;
      time_q  <= '0;
      sec_q   <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      lap_q   <= lap_d;
      time_q  <= time_d;
      sec_q   <= sec_d;
      go_q    <= go_d;
    end
  end

  assign state     = state_q;
  assign countdown = cd_q;
  assign lap_count = lap_q;
  assign race_time = time_q;
  assign go_pulse  = go_q;
  assign phys_tick = tick;

endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer (TICK_DIV=4, TICKS_PER_SEC=2,
// COUNT_SECS=3, NUM_LAPS=2). Pause scenarios build with PAUSE_EN.
module tb_race_sequencer;
  import race_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_btn = 1'b0;
  logic        pause_btn = 1'b0;
  logic        abort = 1'b0;
  logic        lap_pulse = 1'b0;
  logic [2:0]  state;
  logic [2:0]  countdown;
  logic [3:0]  lap_count;
  logic [15:0] race_time;
  logic        go_pulse;
  logic        phys_tick;

  int n_chk = 0;
  int n_bad = 0;
  int go_cnt = 0;

  race_sequencer #(
    .TICK_DIV      (4),
    .TICKS_PER_SEC (2),
    .COUNT_SECS    (3),
    .NUM_LAPS      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .pause_btn (pause_btn),
    .abort     (abort),
    .lap_pulse (lap_pulse),
    .state     (state),
    .countdown (countdown),
    .lap_count (lap_count),
    .race_time (race_time),
    .go_pulse  (go_pulse),
    .phys_tick (phys_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (go_pulse) go_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_start();
    start_btn = 1'b1; @(negedge clk); start_btn = 1'b0;
  endtask

  task automatic press_lap();
    lap_pulse = 1'b1; @(negedge clk); lap_pulse = 1'b0;
  endtask

  task automatic press_abort();
    abort = 1'b1; @(negedge clk); abort = 1'b0;
  endtask

  // Leaves the bench at the negedge right after entry into RACING.
  task automatic race_to_go();
    press_start();
    press_start();
    cyc(24);
  endtask

  initial begin
    // reset state
    #2;
    check("rst_state", state, 0);
    check("rst_cd", countdown, 0);
    check("rst_lap", lap_count, 0);
    check("rst_time", race_time, 0);
    check("rst_go", go_pulse, 0);
    check("rst_tick", phys_tick, 0);
    cyc(2);
    rst = 1'b1;
    cyc(1);

    // start sequence and countdown timing
    press_start();
    check("setting", state, 1);
    press_start();                          // E0
    check("cd_enter", state, 3);
    check("cd_load", countdown, 3);
    cyc(3);                                 // E3
    check("first_tick", phys_tick, 1);
    cyc(4);                                 // E7
    check("cd3_hold", countdown, 3);
    cyc(1);                                 // E8
    check("cd2", countdown, 2);
    cyc(8);                                 // E16
    check("cd1", countdown, 1);
    cyc(7);                                 // E23
    check("cd1_state", state, 3);
    check("go_early", go_pulse, 0);
    cyc(1);                                 // E24
    check("racing", state, 4);
    check("cd0", countdown, 0);
    check("go_high", go_pulse, 1);
    check("time0", race_time, 0);
    cyc(1);                                 // E25
    check("go_once", go_pulse, 0);

    // laps and finish
    cyc(18);                                // E43
    press_lap();                            // E44
    check("lap1", lap_count, 1);
    check("time5", race_time, 5);
    cyc(19);                                // E63
    press_lap();                            // E64
    check("finish", state, 6);
    check("lap2", lap_count, 2);
    check("time10", race_time, 10);
    cyc(10);
    press_lap();
    check("fin_time_hold", race_time, 10);
    check("fin_lap_hold", lap_count, 2);
    check("fin_state_hold", state, 6);
    check("go_count", go_cnt, 1);
    press_start();
    check("fin_idle", state, 0);
    check("fin_clr_lap", lap_count, 0);
    check("fin_clr_time", race_time, 0);
    check("fin_clr_tick", phys_tick, 0);

`ifdef PAUSE_EN
    // pause freezes timer and prescaler
    race_to_go();
    cyc(13);
    pause_btn = 1'b1; @(negedge clk); pause_btn = 1'b0;   // k=14
    check("paused", state, 5);
    check("pause_time", race_time, 3);
    cyc(20);                                              // k=34
    check("pause_time_hold", race_time, 3);
    check("pause_no_tick", phys_tick, 0);
    pause_btn = 1'b1; @(negedge clk); pause_btn = 1'b0;   // k=35
    check("resume", state, 4);
    check("resume_time", race_time, 3);
    cyc(1);                                               // k=36
    check("resume_tick", phys_tick, 1);
    cyc(1);                                               // k=37
    check("resume_time4", race_time, 4);

    // lap + pause coincidence, non-final then final
    lap_pulse = 1'b1; pause_btn = 1'b1; @(negedge clk);
    lap_pulse = 1'b0; pause_btn = 1'b0;                   // k=38
    check("lp_pause_state", state, 5);
    check("lp_pause_lap", lap_count, 1);
    press_lap();                                          // k=39
    check("pause_lap_ign", lap_count, 1);
    check("pause_lap_state", state, 5);
    pause_btn = 1'b1; @(negedge clk); pause_btn = 1'b0;   // k=40
    check("resume2", state, 4);
    lap_pulse = 1'b1; pause_btn = 1'b1; @(negedge clk);
    lap_pulse = 1'b0; pause_btn = 1'b0;                   // k=41
    check("lp_final_state", state, 6);
    check("lp_final_lap", lap_count, 2);
    press_start();
`else
    // pause ignored without the feature
    race_to_go();
    cyc(5);
    pause_btn = 1'b1; @(negedge clk); pause_btn = 1'b0;   // k=6
    check("nopause_state", state, 4);
    cyc(6);                                               // k=12
    check("nopause_time", race_time, 3);
    check("nopause_state2", state, 4);
    press_abort();
`endif

    // abort during countdown
    press_start();
    press_start();
    cyc(10);
    check("pre_abort_cd", countdown, 2);
    press_abort();
    check("abort_state", state, 0);
    check("abort_cd", countdown, 0);
    check("abort_tick", phys_tick, 0);

    // asynchronous reset mid-race
    race_to_go();
    cyc(6);
    press_lap();                                          // k=7
    check("pre_rst_lap", lap_count, 1);
    check("pre_rst_time", race_time, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_lap", lap_count, 0);
    check("arst_time", race_time, 0);
    check("arst_tick", phys_tick, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1);

    // illegal state code recovery
    force dut.state_q = race_state_e'(3'd7);
    #1;
    check("forced7", state, 7);
    release dut.state_q;
    @(negedge clk);
    check("rec7", state, 0);
`ifndef PAUSE_EN
    force dut.state_q = race_state_e'(3'd5);
    #1;
    check("forced5", state, 5);
    release dut.state_q;
    @(negedge clk);
    check("rec5", state, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
